// File: rtl/irq_controller_if.sv
// Request/acknowledge bundle between peripherals, core CSRs and irq_controller.
// "slave" is the controller's view; "master" is the core/peripheral side.
interface irq_controller_if #(
  parameter int unsigned N_IRQ = 16
);
  logic [N_IRQ-1:0] int_req_i;
  logic [31:0]      mie_i;
  logic             INT_RST_i;
  logic             INT_o;
  logic [31:0]      mcause_o;
  logic [N_IRQ-1:0] int_fin_o;

  modport slave (
    input  int_req_i, mie_i, INT_RST_i,
    output INT_o, mcause_o, int_fin_o
  );

  modport master (
    output int_req_i, mie_i, INT_RST_i,
    input  INT_o, mcause_o, int_fin_o
  );
endinterface

// File: rtl/irq_controller.sv
// Round-robin interrupt controller: scans masked level requests, raises INT_o
// with an mcause code, and strobes int_fin_o to the serviced source on INT_RST_i.
module irq_controller #(
  parameter int unsigned N_IRQ = 16,
  localparam int unsigned IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  irq_controller_if.slave    bus
);

  typedef enum logic [1:0] {SCAN, WAIT_ACK, FIN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             int_q, int_d;
  logic [31:0]      mcause_q, mcause_d;
  logic [N_IRQ-1:0] fin_q, fin_d;

  logic [N_IRQ-1:0] mie_n;
  logic             hit;

  assign mie_n = bus.mie_i[N_IRQ-1:0];
  assign hit   = bus.int_req_i[cnt_q] & mie_n[cnt_q];

  // Wrap at N_IRQ-1 rather than at the counter's natural overflow.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    if (x == IDX_W'(N_IRQ - 1)) return '0;
    else                        return x + IDX_W'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= SCAN;
      cnt_q    <= '0;
      idx_q    <= '0;
      int_q    <= 1'b0;
      mcause_q <= '0;
      fin_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      int_q    <= int_d;
      mcause_q <= mcause_d;
      fin_q    <= fin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:     if (hit) state_d = WAIT_ACK;
      WAIT_ACK: if (bus.INT_RST_i) state_d = FIN;
      FIN:      state_d = SCAN;
      default:  state_d = SCAN;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    int_d    = int_q;
    mcause_d = mcause_q;
    fin_d    = '0;
    case (state_q)
      SCAN: begin
        if (hit) begin
          idx_d    = cnt_q;
          mcause_d = {1'b1, 26'b0, 5'(cnt_q)};
          int_d    = 1'b1;
        end else begin
          cnt_d = wrap_inc(cnt_q);
        end
      end
      WAIT_ACK: begin
        if (bus.INT_RST_i) begin
          int_d = 1'b0;
          fin_d = N_IRQ'(1) << idx_q;
        end
      end
      FIN:     cnt_d = wrap_inc(idx_q);
      default: ;
    endcase
  end

  assign bus.INT_o     = int_q;
  assign bus.mcause_o  = mcause_q;
  assign bus.int_fin_o = fin_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller (N_IRQ=16), scan position tracked by hand.
module tb_irq_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  irq_controller_if #(.N_IRQ(16)) bus ();

  irq_controller #(.N_IRQ(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Leaves the DUT just out of reset at a negedge: cnt=0, SCAN.
  task automatic reset_dut();
    bus.INT_RST_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic ack();
    bus.INT_RST_i = 1'b1;
    tick();
    bus.INT_RST_i = 1'b0;
  endtask

  task automatic wait_int(input int max, output int n);
    n = 0;
    while (bus.INT_o !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    bus.int_req_i = '0; bus.mie_i = '0; bus.INT_RST_i = 1'b0;
    tick();
    tests++; if (bus.INT_o !== 1'b0) begin fails++; $display("FAIL reset_int: got %b expected 0", bus.INT_o); end
    tests++; if (bus.mcause_o !== 32'h0) begin fails++; $display("FAIL reset_mcause: got %h expected 00000000", bus.mcause_o); end
    tests++; if (bus.int_fin_o !== 16'h0) begin fails++; $display("FAIL reset_fin: got %h expected 0000", bus.int_fin_o); end
    rst = 1'b0;
    bus.mie_i = 32'h1; bus.int_req_i = 16'h1;
    tick();
    tests++; if (bus.INT_o !== 1'b1) begin fails++; $display("FAIL reset_cnt0: got %b expected 1", bus.INT_o); end
  endtask

  task automatic test_single();
    reset_dut();
    bus.mie_i = 32'h0000_0008; bus.int_req_i = 16'h0008;
    tick(3);
    tests++; if (bus.INT_o !== 1'b0) begin fails++; $display("FAIL single_early: got %b expected 0", bus.INT_o); end
    tick();
    tests++; if (bus.INT_o !== 1'b1) begin fails++; $display("FAIL single_int: got %b expected 1", bus.INT_o); end
    tests++; if (bus.mcause_o !== 32'h8000_0003) begin fails++; $display("FAIL single_mcause: got %h expected 80000003", bus.mcause_o); end
    tick(3);
    tests++; if (bus.INT_o !== 1'b1) begin fails++; $display("FAIL single_hold: got %b expected 1", bus.INT_o); end
    ack();
    tests++; if (bus.int_fin_o !== 16'h0008) begin fails++; $display("FAIL single_fin: got %h expected 0008", bus.int_fin_o); end
    tests++; if (bus.INT_o !== 1'b0) begin fails++; $display("FAIL single_intclr: got %b expected 0", bus.INT_o); end
    bus.int_req_i = '0;
    tick();
    tests++; if (bus.int_fin_o !== 16'h0) begin fails++; $display("FAIL single_fin1cyc: got %h expected 0000", bus.int_fin_o); end
    tests++; if (bus.mcause_o !== 32'h8000_0003) begin fails++; $display("FAIL single_retain: got %h expected 80000003", bus.mcause_o); end
  endtask

  task automatic test_masked();
    int n;
    logic seen;
    reset_dut();
    bus.mie_i = '0; bus.int_req_i = 16'h0020;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.INT_o === 1'b1) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL masked_quiet: got %b expected 0", seen); end
    // cnt is now 8; source 5 is reached after 14 edges.
    bus.mie_i = 32'h0000_0020;
    wait_int(16, n);
    tests++; if (n !== 14) begin fails++; $display("FAIL masked_latency: got %0d expected 14", n); end
    tests++; if (bus.mcause_o !== 32'h8000_0005) begin fails++; $display("FAIL masked_mcause: got %h expected 80000005", bus.mcause_o); end
  endtask

  task automatic test_round_robin();
    int n;
    reset_dut();
    bus.mie_i = '1; bus.int_req_i = 16'h0006;
    tick(2);
    tests++; if (bus.mcause_o !== 32'h8000_0001 || bus.INT_o !== 1'b1) begin fails++; $display("FAIL rr_first: got %h/%b expected 80000001/1", bus.mcause_o, bus.INT_o); end
    ack();
    tests++; if (bus.int_fin_o !== 16'h0002) begin fails++; $display("FAIL rr_fin1: got %h expected 0002", bus.int_fin_o); end
    bus.int_req_i = 16'h0004;
    tick();
    bus.int_req_i = 16'h0006;
    tick();
    tests++; if (bus.mcause_o !== 32'h8000_0002 || bus.INT_o !== 1'b1) begin fails++; $display("FAIL rr_second: got %h/%b expected 80000002/1", bus.mcause_o, bus.INT_o); end
    ack();
    tests++; if (bus.int_fin_o !== 16'h0004) begin fails++; $display("FAIL rr_fin2: got %h expected 0004", bus.int_fin_o); end
    bus.int_req_i = 16'h0002;
    tick();
    wait_int(20, n);
    tests++; if (n !== 15) begin fails++; $display("FAIL rr_rescan: got %0d expected 15", n); end
    tests++; if (bus.mcause_o !== 32'h8000_0001) begin fails++; $display("FAIL rr_third: got %h expected 80000001", bus.mcause_o); end
  endtask

  task automatic test_mid_service();
    reset_dut();
    bus.mie_i = '1; bus.int_req_i = 16'h0004;
    tick(3);
    tests++; if (bus.INT_o !== 1'b1) begin fails++; $display("FAIL mid_int: got %b expected 1", bus.INT_o); end
    bus.int_req_i = '0; bus.mie_i = '0;
    tick(3);
    tests++; if (bus.INT_o !== 1'b1) begin fails++; $display("FAIL mid_hold: got %b expected 1", bus.INT_o); end
    tests++; if (bus.mcause_o !== 32'h8000_0002) begin fails++; $display("FAIL mid_mcause: got %h expected 80000002", bus.mcause_o); end
    ack();
    tests++; if (bus.int_fin_o !== 16'h0004) begin fails++; $display("FAIL mid_fin: got %h expected 0004", bus.int_fin_o); end
  endtask

  task automatic test_spurious_wrap();
    reset_dut();
    bus.mie_i = '1; bus.int_req_i = '0;
    tick(2);
    ack();
    tests++; if (bus.int_fin_o !== 16'h0 || bus.INT_o !== 1'b0) begin fails++; $display("FAIL spur_fin: got %h/%b expected 0000/0", bus.int_fin_o, bus.INT_o); end
    bus.int_req_i = 16'h0008;
    tick();
    tests++; if (bus.INT_o !== 1'b1 || bus.mcause_o !== 32'h8000_0003) begin fails++; $display("FAIL spur_scan: got %b/%h expected 1/80000003", bus.INT_o, bus.mcause_o); end

    reset_dut();
    bus.mie_i = '1; bus.int_req_i = 16'h8000;
    tick(15);
    tests++; if (bus.INT_o !== 1'b0) begin fails++; $display("FAIL wrap_early: got %b expected 0", bus.INT_o); end
    tick();
    tests++; if (bus.INT_o !== 1'b1 || bus.mcause_o !== 32'h8000_000F) begin fails++; $display("FAIL wrap_15: got %b/%h expected 1/8000000f", bus.INT_o, bus.mcause_o); end
    ack();
    tests++; if (bus.int_fin_o !== 16'h8000) begin fails++; $display("FAIL wrap_fin: got %h expected 8000", bus.int_fin_o); end
    bus.int_req_i = 16'h0001;
    tick(2);
    tests++; if (bus.INT_o !== 1'b1 || bus.mcause_o !== 32'h8000_0000) begin fails++; $display("FAIL wrap_cnt0: got %b/%h expected 1/80000000", bus.INT_o, bus.mcause_o); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    reset_dut();
    bus.mie_i = '1; bus.int_req_i = 16'h0002;
    tick(2);
    tests++; if (bus.INT_o !== 1'b1) begin fails++; $display("FAIL rstmid_pre: got %b expected 1", bus.INT_o); end
    #3 rst = 1'b1;
    #1;
    tests++; if (bus.INT_o !== 1'b0 || bus.mcause_o !== 32'h0 || bus.int_fin_o !== 16'h0) begin fails++; $display("FAIL rstmid_async: got %b/%h/%h expected 0/00000000/0000", bus.INT_o, bus.mcause_o, bus.int_fin_o); end
    bus.int_req_i = '0;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    bus.INT_RST_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.int_fin_o !== 16'h0) seen = 1'b1;
    end
    bus.INT_RST_i = 1'b0;
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rstmid_nofin: got %b expected 0", seen); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_masked();
    test_round_robin();
    test_mid_service();
    test_spurious_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
